mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have no parameters; address 32 b, RAM port 8 b, fixed.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 rdy  in  1  global ready; low = pause.
REQ-005 if_req  in  1  instruction-fetch request, held high until if_done.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_flush  in  1  branch cancel; aborts an IF transaction.
REQ-008 if_done  out  1  one-cycle pulse, if_inst valid.
REQ-009 if_inst  out  32  fetched word, little-endian.
REQ-010 mem_req  in  1  load/store request, held high until mem_done.
REQ-011 mem_we  in  1  1 = store, 0 = load.
REQ-012 mem_addr  in  32  load/store base byte address.
REQ-013 mem_len  in  2  0 = byte, 1 = half, 2 = word; 3 treated as word.
REQ-014 mem_wdata  in  32  store data, low N bytes used.
REQ-015 mem_done  out  1  one-cycle pulse, transaction complete.
REQ-016 mem_rdata  out  32  load data, zero-extended.
REQ-017 ram_din  in  8  RAM read byte, valid one cycle after its address.
REQ-018 ram_dout  out  8  RAM write byte.
REQ-019 ram_addr  out  32  RAM byte address.
REQ-020 ram_wr  out  1  RAM write strobe.

Function
REQ-021 States SHALL be IDLE, READ, WRITE, DONE; owner register = IF or MEM; byte count N = 4 for IF, 1/2/4 for MEM.
REQ-022 IDLE: mem_req has priority over if_req; winner's address, N, we latched at the edge; next state READ (load/fetch) or WRITE (store).
REQ-023 No preemption: a started transaction SHALL finish before any other is accepted.
REQ-024 READ cycle j (j = 0..N): ram_addr = base+j for j < N; for j >= 1 ram_din captured into byte j-1 (bits 8(j-1)+7:8(j-1)); after cycle j = N go DONE.
REQ-025 WRITE cycle j (j = 0..N-1): ram_wr = 1, ram_addr = base+j, ram_dout = mem_wdata byte j; after j = N-1 go DONE.
REQ-026 DONE: owner's done = 1 for exactly one cycle with data stable; next state IDLE; requests ignored in DONE.
REQ-027 Latency from accept edge to done high: read N+1 edges (word 5, byte 2), write N edges.
REQ-028 In IDLE, READ, DONE: ram_wr = 0; in IDLE/DONE ram_addr = 0, ram_dout = 0.
REQ-029 Address increment SHALL be 32-bit wrap-around; unaligned bases allowed.
REQ-030 Unused upper bytes of mem_rdata SHALL be 0 (sign extension is the MEM stage's job).
REQ-031 rdy = 0: state, counters, captured data frozen; ram_wr forced 0; no capture; done pulse held until rdy returns (pulse then completes).
REQ-032 if_flush = 1 with owner IF in READ or DONE: next state IDLE, if_done suppressed; flush in IDLE blocks IF acceptance that edge; flush never affects MEM owner.
REQ-033 Simultaneous if_req and mem_req in IDLE: MEM served first, IF accepted at the first IDLE after MEM's DONE.

Reset
REQ-034 rst low: state IDLE, counters 0, all outputs 0, if_inst/mem_rdata 0, immediately (asynchronous).
REQ-035 First accept possible at the first rising edge after rst deasserts.

Verification
REQ-036 IF fetch addr 0x100, RAM bytes 13,01,00,00 -> ram_addr 0x100..0x103, if_inst = 0x00000113, if_done pulse 5 edges after accept.
REQ-037 Store word 0xDEADBEEF to 0x200 -> ram_wr 4 cycles, bytes EF,BE,AD,DE at 0x200..0x203, mem_done 4 edges after accept.
REQ-038 if_req and mem_req (byte load 0x30000, din 0x41) same cycle -> MEM first, mem_rdata = 0x00000041, then IF fetch starts after DONE.
REQ-039 rdy low 3 cycles mid word store -> no repeated or lost byte, ram_wr 0 during pause, completion delayed exactly 3 cycles.
REQ-040 if_flush during IF READ j = 2 -> IDLE next edge, no if_done; pending mem_req accepted next IDLE; rst low mid-store -> outputs 0 at once.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/response and RAM-side signals of the two-requester byte-RAM arbiter.
// slave is the arbiter's view; master is the requesters' and RAM's view.
interface mem_arbiter_if;
  logic        rdy;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_done;
  logic [31:0] if_inst;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  mem_len;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_addr;
  logic        ram_wr;

  modport slave (
    input  rdy, if_req, if_addr, if_flush, mem_req, mem_we, mem_addr, mem_len, mem_wdata, ram_din,
    output if_done, if_inst, mem_done, mem_rdata, ram_dout, ram_addr, ram_wr
  );

  modport master (
    output rdy, if_req, if_addr, if_flush, mem_req, mem_we, mem_addr, mem_len, mem_wdata, ram_din,
    input  if_done, if_inst, mem_done, mem_rdata, ram_dout, ram_addr, ram_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store requests onto a single 8-bit RAM port,
// moving one byte per cycle; MEM wins ties, no preemption, IF can be flushed.
module mem_arbiter (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  typedef enum logic {OWN_IF, OWN_MEM} owner_t;

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [31:0] base_q, base_d;
  logic [2:0]  n_q, n_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic [31:0] cur_addr;

  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  // Wraps naturally at 2^32, so unaligned bases near the top roll over to 0.
  assign cur_addr      = base_q + {29'd0, cnt_q};
  assign bus.if_inst   = data_q;
  assign bus.mem_rdata = data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      base_q  <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q  <= base_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    base_d       = base_q;
    n_d          = n_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    bus.if_done  = 1'b0;
    bus.mem_done = 1'b0;
    bus.ram_wr   = 1'b0;
    bus.ram_addr = '0;
    bus.ram_dout = '0;
    case (state_q)
      IDLE: begin
        // Clearing the capture register at accept keeps short loads zero-extended.
        if (bus.rdy) begin
          if (bus.mem_req) begin
            state_d = bus.mem_we ? WRITE : READ;
            owner_d = OWN_MEM;
            base_d  = bus.mem_addr;
            n_d     = len_to_n(bus.mem_len);
            cnt_d   = '0;
            data_d  = '0;
          end else if (bus.if_req && !bus.if_flush) begin
            state_d = READ;
            owner_d = OWN_IF;
            base_d  = bus.if_addr;
            n_d     = 3'd4;
            cnt_d   = '0;
            data_d  = '0;
          end
        end
      end
      READ: begin
        if (cnt_q < n_q) bus.ram_addr = cur_addr;
        if (bus.rdy) begin
          if (owner_q == OWN_IF && bus.if_flush) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            // ram_din lags its address by one cycle, so cycle j fills byte j-1.
            if (cnt_q != 3'd0) data_d = put_byte(data_q, cnt_q[1:0] - 2'd1, bus.ram_din);
            if (cnt_q == n_q) begin
              state_d = DONE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
      end
      WRITE: begin
        bus.ram_addr = cur_addr;
        bus.ram_dout = byte_sel(bus.mem_wdata, cnt_q[1:0]);
        bus.ram_wr   = bus.rdy;
        if (bus.rdy) begin
          if (cnt_q == n_q - 3'd1) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      DONE: begin
        if (owner_q == OWN_MEM) bus.mem_done = 1'b1;
        else                    bus.if_done  = !bus.if_flush;
        if (bus.rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
